fsmc_slave_bridge: RTL

Parametrised successor to the fixed 16-bit FSMC front end of the SDRAM tester system. Samples the asynchronous STM32 FSMC NOR/SRAM strobes into the clk domain and converts each host access into one transaction on a valid/ready request port with a response port. Adds byte lanes, NWAIT-driven read stalling, read timeout and error counting. Sits between the top-level FSMC pads (tristate done at top) and the SDRAM controller front end.

---
 rtl/fsmc_slave_bridge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fsmc_slave_bridge.sv
// STM32 FSMC NOR/SRAM slave front end: synchronises the host strobes and turns each
// host access into one valid/ready request, with NWAIT read stalling, read timeout and error counting.
module fsmc_slave_bridge #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 2,
   parameter int RD_TIMEOUT  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     fsmc_a,
   input  logic [DATA_W-1:0]     fsmc_d_i,
   output logic [DATA_W-1:0]     fsmc_d_o,
   output logic                  fsmc_d_oe,
   input  logic                  fsmc_ne1,
   input  logic                  fsmc_nwe,
   input  logic                  fsmc_noe,
   input  logic [DATA_W/8-1:0]   fsmc_nbl,
   output logic                  fsmc_nwait,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_we,
   output logic [ADDR_W-1:0]     req_addr,
   output logic [DATA_W-1:0]     req_wdata,
   output logic [DATA_W/8-1:0]   req_be,
   input  logic                  rsp_valid,
   input  logic [DATA_W-1:0]     rsp_rdata,
   output logic                  err_pulse,
   output logic [7:0]            err_count
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(SETTLE_CYC + SYNC_STAGES + 1);
   localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_ARM, ST_IDLE, ST_WR_SETTLE, ST_WR_REQ, ST_RD_SETTLE, ST_RD_REQ, ST_RD_WAIT, ST_HOLD
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ne1_sync_q, nwe_sync_q, noe_sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   err_seen_q, err_seen_d;
   logic                   drive_q, drive_d;
   logic                   nwait_q, nwait_d;
   logic                   req_valid_q, req_valid_d;
   logic                   req_we_q, req_we_d;
   logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
   logic [DATA_W-1:0]      req_wdata_q, req_wdata_d;
   logic [BE_W-1:0]        req_be_q, req_be_d;
   logic [DATA_W-1:0]      d_o_q, d_o_d;
   logic                   err_pulse_q, err_pulse_d;
   logic [7:0]             err_count_q, err_count_d;

   logic ne1_s, nwe_s, noe_s;
   logic wr_cond_s, rd_cond_s, all_low_s, released_s, rd_rel_s, timeout_s;

   // Strobe synchronisers; idle (high) out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ne1_sync_q <= {SYNC_STAGES{1'b1}};
         nwe_sync_q <= {SYNC_STAGES{1'b1}};
         noe_sync_q <= {SYNC_STAGES{1'b1}};
      end else begin
         ne1_sync_q <= {ne1_sync_q[SYNC_STAGES-2:0], fsmc_ne1};
         nwe_sync_q <= {nwe_sync_q[SYNC_STAGES-2:0], fsmc_nwe};
         noe_sync_q <= {noe_sync_q[SYNC_STAGES-2:0], fsmc_noe};
      end
   end

   assign ne1_s      = ne1_sync_q[SYNC_STAGES-1];
   assign nwe_s      = nwe_sync_q[SYNC_STAGES-1];
   assign noe_s      = noe_sync_q[SYNC_STAGES-1];
   assign wr_cond_s  = ~ne1_s & ~nwe_s & noe_s;
   assign rd_cond_s  = ~ne1_s & ~noe_s & nwe_s;
   assign all_low_s  = ~ne1_s & ~nwe_s & ~noe_s;
   assign released_s = ne1_s | (nwe_s & noe_s);
   assign rd_rel_s   = ne1_s | noe_s;
   assign timeout_s  = (tmr_q == TMR_W'(RD_TIMEOUT - 1));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_ARM;
         cnt_q       <= '0;
         tmr_q       <= '0;
         err_seen_q  <= 1'b0;
         drive_q     <= 1'b0;
         nwait_q     <= 1'b1;
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_be_q    <= '0;
         d_o_q       <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         err_seen_q  <= err_seen_d;
         drive_q     <= drive_d;
         nwait_q     <= nwait_d;
         req_valid_q <= req_valid_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_be_q    <= req_be_d;
         d_o_q       <= d_o_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      err_seen_d  = err_seen_q;
      drive_d     = drive_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_be_d    = req_be_q;
      d_o_d       = d_o_q;
      err_pulse_d = 1'b0;
      case (state_q)
         // ARM waits for the synchronisers to refill before trusting ne1.
         ST_ARM: begin
            if (cnt_q != CNT_W'(SYNC_STAGES)) cnt_d = cnt_q + 1'b1;
            else if (ne1_s)                   state_d = ST_IDLE;
            else                              state_d = ST_ARM;
         end
         ST_IDLE: begin
            cnt_d = '0;
            if (all_low_s) begin
               err_pulse_d = 1'b1;
               state_d     = ST_HOLD;
            end else if (wr_cond_s) state_d = ST_WR_SETTLE;
            else if (rd_cond_s)     state_d = ST_RD_SETTLE;
            else                    state_d = ST_IDLE;
         end
         ST_WR_SETTLE: begin
            if (!wr_cond_s) begin
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               req_we_d    = 1'b1;
               req_addr_d  = fsmc_a;
               req_wdata_d = fsmc_d_i;
               req_be_d    = ~fsmc_nbl;
               state_d     = ST_WR_REQ;
            end else cnt_d = cnt_q + 1'b1;
         end
         ST_WR_REQ: begin
            if (req_valid_q && req_ready) state_d = ST_HOLD;
            else                          state_d = ST_WR_REQ;
         end
         ST_RD_SETTLE: begin
            if (!rd_cond_s) begin
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               req_we_d   = 1'b0;
               req_addr_d = fsmc_a;
               req_be_d   = ~fsmc_nbl;
               state_d    = ST_RD_REQ;
            end else cnt_d = cnt_q + 1'b1;
         end
         ST_RD_REQ: begin
            if (req_valid_q && req_ready) begin
               tmr_d      = '0;
               err_seen_d = 1'b0;
               state_d    = ST_RD_WAIT;
            end else state_d = ST_RD_REQ;
         end
         // A host release here is flagged once, but the response is still consumed.
         ST_RD_WAIT: begin
            if ((rd_rel_s || (timeout_s && !rsp_valid)) && !err_seen_q) begin
               err_pulse_d = 1'b1;
               err_seen_d  = 1'b1;
            end
            if (rsp_valid) begin
               d_o_d   = rsp_rdata;
               drive_d = 1'b1;
               state_d = ST_HOLD;
            end else if (timeout_s) begin
               d_o_d   = {DATA_W{1'b1}};
               drive_d = 1'b1;
               state_d = ST_HOLD;
            end else tmr_d = tmr_q + 1'b1;
         end
         ST_HOLD: begin
            if (released_s) begin
               drive_d = 1'b0;
               state_d = ST_IDLE;
            end else state_d = ST_HOLD;
         end
         default: state_d = ST_ARM;
      endcase
      req_valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
      nwait_d     = !((state_d == ST_RD_SETTLE) || (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT));
      if (err_pulse_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      else                                       err_count_d = err_count_q;
   end

   assign fsmc_d_oe  = drive_q & ~fsmc_ne1 & ~fsmc_noe;
   assign fsmc_d_o   = d_o_q;
   assign fsmc_nwait = nwait_q;
   assign req_valid  = req_valid_q;
   assign req_we     = req_we_q;
   assign req_addr   = req_addr_q;
   assign req_wdata  = req_wdata_q;
   assign req_be     = req_be_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;

endmodule
